control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/reg_decoder.sv | 9 +
 rtl/control_sequencer.sv | 112 +++++++++++
 tb/tb_control_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states and one-hot ALU operation indices
// Used by control_sequencer and by the datapath ALU.
package cpu_pkg;
  typedef enum logic [3:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_DIV  = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;
  localparam int ALU_W    = 13;
  // an all-zero result marks an illegal opcode
  function automatic logic [ALU_W-1:0] alu_decode(input logic [4:0] op);
    logic [ALU_W-1:0] v;
    v = '0;
    case (op)
      OP_ADD:  v[ALU_ADD]  = 1'b1;
      OP_SUB:  v[ALU_SUB]  = 1'b1;
      OP_AND:  v[ALU_AND]  = 1'b1;
      OP_OR:   v[ALU_OR]   = 1'b1;
      OP_SHR:  v[ALU_SHR]  = 1'b1;
      OP_SHRA: v[ALU_SHRA] = 1'b1;
      OP_SHL:  v[ALU_SHL]  = 1'b1;
      OP_ROR:  v[ALU_ROR]  = 1'b1;
      OP_ROL:  v[ALU_ROL]  = 1'b1;
      OP_MUL:  v[ALU_MUL]  = 1'b1;
      OP_DIV:  v[ALU_DIV]  = 1'b1;
      OP_NEG:  v[ALU_NEG]  = 1'b1;
      OP_NOT:  v[ALU_NOT]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/reg_decoder.sv
// reg_decoder: 4-bit register index to 16-bit one-hot enable
// Ports: idx (register number), en (gate), onehot (bit idx set when en).
module reg_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);
  assign onehot = en ? (16'd1 << idx) : 16'd0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit stepping fetch and ALU execute states
// Ports: clock, clear (async active-low), start, mem_ready, IR in;
// datapath strobes, one-hot Rin/Rout, one-hot alu_op, busy/done/illegal out.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [31:0]       IR,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDMuxread,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zhighin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              HIin,
  output logic              LOin,
  output logic [15:0]       Rin,
  output logic [15:0]       Rout,
  output logic [ALU_W-1:0]  alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal
);
  state_t state_q, state_d;
  logic t1_wait_q, t1_wait_d;
  logic [ALU_W-1:0] alu_vec;
  logic legal, muldiv, unary, rin_en, rout_en;
  logic [3:0] rout_idx;
  logic unused_ir;
  assign unused_ir = &{1'b0, IR[14:0]};
  assign alu_vec = alu_decode(IR[31:27]);
  assign legal = |alu_vec;
  assign muldiv = alu_vec[ALU_MUL] | alu_vec[ALU_DIV];
  assign unary = alu_vec[ALU_NEG] | alu_vec[ALU_NOT];
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      state_q <= S_IDLE;
      t1_wait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  // t1_wait_q marks T1 cycles after the first, so the PC write-back fires once
  always_comb begin
    state_d = state_q;
    t1_wait_d = 1'b0;
    {PCout, PCin, IncPC, MARin, MDMuxread, MDRin, MDRout, IRin} = '0;
    {Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, done} = '0;
    alu_op = '0;
    rin_en = 1'b0;
    rout_en = 1'b0;
    rout_idx = IR[22:19];
    case (state_q)
      S_IDLE: state_d = start ? S_T0 : S_IDLE;
      S_T0: begin
        {PCout, MARin, IncPC, Zlowin} = '1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = !t1_wait_q;
        PCin = !t1_wait_q;
        {MDMuxread, MDRin} = '1;
        t1_wait_d = !mem_ready;
        state_d = mem_ready ? S_T2 : S_T1;
      end
      S_T2: begin
        {MDRout, IRin} = '1;
        state_d = S_T3;
      end
      S_T3: begin
        rout_en = legal;
        Yin = legal;
        state_d = legal ? S_T4 : S_HALT;
      end
      S_T4: begin
        rout_en = 1'b1;
        rout_idx = unary ? IR[22:19] : IR[18:15];
        alu_op = alu_vec;
        Zlowin = 1'b1;
        Zhighin = muldiv;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        rin_en = !muldiv;
        LOin = muldiv;
        done = !muldiv;
        state_d = muldiv ? S_T6 : S_IDLE;
      end
      S_T6: begin
        {Zhighout, HIin, done} = '1;
        state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
  assign busy = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = state_q == S_HALT;
  reg_decoder u_rin (.idx(IR[26:23]), .en(rin_en), .onehot(Rin));
  reg_decoder u_rout (.idx(rout_idx), .en(rout_en), .onehot(Rout));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of control_sequencer against a small datapath model
module tb_control_sequencer;
  logic clock = 1'b0, clear, start, mem_ready;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDMuxread, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, busy, done, illegal;
  logic [15:0] Rin, Rout;
  logic [12:0] alu_op;
  int n_chk = 0, n_pass = 0;
  logic oh_bad = 1'b0;
  logic [31:0] r [16];
  logic [31:0] y, zlo, zhi, lo, hi, bus, sh;
  logic [63:0] res;
  int cyc, pc_n, mdr_n;
  control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDMuxread(MDMuxread),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );
  always #5 clock = ~clock;
  always @* begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | r[i];
    sh = $signed(y) >>> bus[4:0];
    res = '0;
    if (alu_op[0]) res = {32'd0, y + bus};
    if (alu_op[7]) res = {32'd0, sh};
    if (alu_op[2]) res = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
  end
  always @(posedge clock or negedge clear)
    if (!clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      r[2] <= 32'h8000FFFF;
      r[3] <= 32'd16;
      {y, zlo, zhi, lo, hi} <= '0;
    end else begin
      if (Yin) y <= bus;
      if (Zlowin) zlo <= res[31:0];
      if (Zhighin) zhi <= res[63:32];
      if (Zlowout) for (int i = 0; i < 16; i++) if (Rin[i]) r[i] <= zlo;
      if (LOin && Zlowout) lo <= zlo;
      if (HIin && Zhighout) hi <= zhi;
    end
  always @(negedge clock)
    if (!($onehot0(Rin) && $onehot0(Rout) && $onehot0(alu_op))) oh_bad <= 1'b1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic launch(input logic [31:0] ir);
    IR = ir;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic run(input logic [31:0] ir, input int stall);
    int s;
    s = stall;
    launch(ir);
    cyc = 1;
    pc_n = 0;
    mdr_n = 0;
    while (!done && cyc < 40) begin
      if (PCin) pc_n++;
      if (MDRin) mdr_n++;
      mem_ready = !(MDRin && s > 0);
      if (MDRin && s > 0) s--;
      tick;
      cyc++;
    end
    mem_ready = 1'b1;
  endtask
  initial begin
    clear = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    IR = '0;
    #1;
    chk("reset_flags", {busy, done, illegal}, 3'b000);
    chk("reset_rout", Rout, 16'h0);
    tick;
    tick;
    clear = 1'b1;
    launch(32'h40918000);
    chk("shra_t0", {PCout, MARin, IncPC, Zlowin, busy}, 5'h1F);
    tick;
    chk("shra_t1", {PCin, Zlowout, MDRin, MDMuxread}, 4'hF);
    tick;
    chk("shra_t2", {MDRout, IRin}, 2'b11);
    tick;
    chk("shra_t3_rout", Rout, 16'h0004);
    chk("shra_t3_yin", Yin, 1'b1);
    tick;
    chk("shra_t4_rout", Rout, 16'h0008);
    chk("shra_t4_alu", alu_op, 13'h0080);
    tick;
    chk("shra_t5", {Rin, Zlowout, done, alu_op}, {16'h0002, 2'b11, 13'h0});
    tick;
    chk("shra_idle", {busy, done}, 2'b00);
    chk("shra_r1", r[1], 32'hFFFF8000);
    run(32'h18918000, 3);
    chk("add_lat", cyc, 9);
    chk("add_pcin", pc_n, 1);
    chk("add_mdrin", mdr_n, 4);
    tick;
    chk("add_r1", r[1], 32'h8001000F);
    launch(32'h60918000);
    tick;
    tick;
    tick;
    tick;
    chk("mul_t4", {Zlowin, Zhighin, alu_op}, {2'b11, 13'h0004});
    tick;
    chk("mul_t5", {LOin, Rin, done}, {1'b1, 16'h0, 1'b0});
    tick;
    chk("mul_t6", {HIin, Zhighout, done, busy}, 4'hF);
    tick;
    chk("mul_lohi", {hi, lo}, 64'hFFFFFFF8_000FFFF0);
    run(32'h60918000, 0);
    chk("mul_lat", cyc, 7);
    tick;
    launch(32'hF8000000);
    tick;
    tick;
    tick;
    chk("ill_t3", {Rout, Yin, illegal}, 18'h0);
    tick;
    chk("ill_halt", {illegal, busy}, 2'b10);
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    chk("ill_sticky", {illegal, busy, PCout, MARin, Rout}, {2'b10, 18'h0});
    #2 clear = 1'b0;
    #1;
    chk("ill_cleared", illegal, 1'b0);
    clear = 1'b1;
    tick;
    launch(32'h18918000);
    tick;
    tick;
    tick;
    tick;
    chk("async_pre", alu_op, 13'h0001);
    #2 clear = 1'b0;
    #1;
    chk("async_now", {busy, done, illegal, Zlowin, alu_op, Rout, Rin}, 64'h0);
    clear = 1'b1;
    run(32'h18918000, 0);
    chk("async_rerun_lat", cyc, 6);
    tick;
    chk("async_rerun_r1", r[1], 32'h8001000F);
    chk("onehot", oh_bad, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
